// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port writeback arbiter for the register-file write port
//
// Ports A (ALU/link) and B (load) each feed a one-entry holding slot through a
// valid/ready handshake. Each edge at most one held entry is granted. The grant
// drives a registered write strobe, address and data into the register-file
// write decoder.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   a_valid/a_ready         port A handshake; a_ready = slot A empty
//   a_addr/a_data           port A destination register and write data
//   b_valid/b_ready         port B handshake; b_ready = slot B empty
//   b_addr/b_data           port B destination register and write data
//   wb_we/wb_addr/wb_data   registered register-file write port
//   busy_vec                bit i set while either slot holds destination i
//
// Optional feature macro: ARB_AGING_EN. When it is defined, port B gains
// priority after MAX_WAIT lost grants.

module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_data,
  output logic                  wb_we,
  output logic [ADDR_W-1:0]     wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int NREG = 2**ADDR_W;

  // Holding slots
  logic              a_full_q, a_full_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic              b_full_q, b_full_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;

  // age_q = 1 means slot B holds the older entry
  logic              age_q, age_d;

  // Registered write port
  logic              wb_we_q, wb_we_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic a_acc, b_acc;
  logic grant_a, grant_b;

`ifdef ARB_AGING_EN
  logic [3:0] wait_q, wait_d;
`else
  logic [3:0] unused_max_wait;
  assign unused_max_wait = 4'(MAX_WAIT);
`endif

  // Accept only into an empty slot; register 0 is a sink, so its handshake
  // completes without storing anything.
  assign a_acc = a_valid && !a_full_q && (a_addr != '0);
  assign b_acc = b_valid && !b_full_q && (b_addr != '0);

  // Grant is a function of slot registers only, so there is no input-to-output path.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full_q && b_full_q) begin
      if (a_addr_q == b_addr_q) begin
        // Same destination: write the older entry first so the newer value lands last
        grant_b = age_q;
        grant_a = !age_q;
      end else begin
`ifdef ARB_AGING_EN
        grant_b = (wait_q >= 4'(MAX_WAIT));
        grant_a = !grant_b;
`else
        grant_a = 1'b1;
`endif
      end
    end else begin
      grant_a = a_full_q;
      grant_b = b_full_q;
    end
  end

  // Next-state logic
  always_comb begin
    a_full_d  = a_full_q;
    a_addr_d  = a_addr_q;
    a_data_d  = a_data_q;
    b_full_d  = b_full_q;
    b_addr_d  = b_addr_q;
    b_data_d  = b_data_q;
    age_d     = age_q;
    wb_we_d   = grant_a || grant_b;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    // A slot cannot be granted and refilled on the same edge, because ready
    // comes from the full flag.
    if (grant_a) begin
      a_full_d = 1'b0;
    end else if (a_acc) begin
      a_full_d = 1'b1;
      a_addr_d = a_addr;
      a_data_d = a_data;
    end

    if (grant_b) begin
      b_full_d = 1'b0;
    end else if (b_acc) begin
      b_full_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_data;
    end

    // Entries that land together are ordered B first, then A.
    if (a_acc && b_acc) begin
      age_d = 1'b1;
    end else if (a_acc && b_full_q && !grant_b) begin
      age_d = 1'b1;
    end else if (b_acc && a_full_q && !grant_a) begin
      age_d = 1'b0;
    end

    if (grant_a) begin
      wb_addr_d = a_addr_q;
      wb_data_d = a_data_q;
    end else if (grant_b) begin
      wb_addr_d = b_addr_q;
      wb_data_d = b_data_q;
    end
  end

`ifdef ARB_AGING_EN
  // Counts grants B loses while it waits. The count saturates so it cannot wrap
  // back below MAX_WAIT.
  always_comb begin
    wait_d = wait_q;
    if (!b_full_q || grant_b) begin
      wait_d = 4'd0;
    end else if (grant_a && (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full_q  <= 1'b0;
      a_addr_q  <= '0;
      a_data_q  <= '0;
      b_full_q  <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      age_q     <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
`ifdef ARB_AGING_EN
      wait_q    <= 4'd0;
`endif
    end else begin
      a_full_q  <= a_full_d;
      a_addr_q  <= a_addr_d;
      a_data_q  <= a_data_d;
      b_full_q  <= b_full_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      age_q     <= age_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
`ifdef ARB_AGING_EN
      wait_q    <= wait_d;
`endif
    end
  end

  // Pending destinations. Register 0 is never stored, so bit 0 stays clear.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NREG; i++) begin
      busy_vec[i] = (a_full_q && (a_addr_q == ADDR_W'(i))) ||
                    (b_full_q && (b_addr_q == ADDR_W'(i)));
    end
  end

  assign a_ready = !a_full_q;
  assign b_ready = !b_full_q;
  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;

  int total;
  int bad;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .busy_vec (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: outputs expected at this falling edge, then inputs driven for the next rising edge
  typedef struct {
    logic        ear;
    logic        ebr;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [31:0] ebusy;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic ear, logic ebr, logic ewe, logic [4:0] ewa,
                              logic [31:0] ewd, logic [31:0] ebusy,
                              logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd);
    vec_t v;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.ebusy = ebusy;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  initial begin
    int n;
    int bc;
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b0;

    //          ear ebr we  wa  wd            busy                     av aa  ad            bv ba  bd
    vecs[0]  = mk(1, 1, 0, 0,  32'h0,        32'h0,                   1, 8,  32'h12345678, 0, 0,  32'h0);
    vecs[1]  = mk(0, 1, 0, 0,  32'h0,        32'h1 << 8,              0, 0,  32'h0,        0, 0,  32'h0);
    vecs[2]  = mk(1, 1, 1, 8,  32'h12345678, 32'h0,                   0, 0,  32'h0,        0, 0,  32'h0);
    vecs[3]  = mk(1, 1, 0, 8,  32'h12345678, 32'h0,                   1, 9,  32'hA,        1, 10, 32'hB);
    vecs[4]  = mk(0, 0, 0, 8,  32'h12345678, (32'h1<<9)|(32'h1<<10), 0, 0,  32'h0,        0, 0,  32'h0);
    vecs[5]  = mk(1, 0, 1, 9,  32'hA,        32'h1 << 10,             0, 0,  32'h0,        0, 0,  32'h0);
    vecs[6]  = mk(1, 1, 1, 10, 32'hB,        32'h0,                   1, 5,  32'h1,        1, 5,  32'h2);
    vecs[7]  = mk(0, 0, 0, 10, 32'hB,        32'h1 << 5,              0, 0,  32'h0,        0, 0,  32'h0);
    vecs[8]  = mk(0, 1, 1, 5,  32'h2,        32'h1 << 5,              0, 0,  32'h0,        0, 0,  32'h0);
    vecs[9]  = mk(1, 1, 1, 5,  32'h1,        32'h0,                   1, 0,  32'hDEAD,     0, 0,  32'h0);
    vecs[10] = mk(1, 1, 0, 5,  32'h1,        32'h0,                   0, 0,  32'h0,        0, 0,  32'h0);
    vecs[11] = mk(1, 1, 0, 5,  32'h1,        32'h0,                   1, 7,  32'h70,       0, 0,  32'h0);
    vecs[12] = mk(0, 1, 0, 5,  32'h1,        32'h1 << 7,              0, 0,  32'h0,        1, 7,  32'h71);
    vecs[13] = mk(1, 0, 1, 7,  32'h70,       32'h1 << 7,              1, 7,  32'h72,       0, 0,  32'h0);
    vecs[14] = mk(0, 1, 1, 7,  32'h71,       32'h1 << 7,              0, 0,  32'h0,        0, 0,  32'h0);
    vecs[15] = mk(1, 1, 1, 7,  32'h72,       32'h0,                   1, 4,  32'h40,       1, 3,  32'h30);
    vecs[16] = mk(0, 0, 0, 7,  32'h72,       (32'h1<<3)|(32'h1<<4),  1, 6,  32'h60,       0, 0,  32'h0);
    vecs[17] = mk(1, 0, 1, 4,  32'h40,       32'h1 << 3,              1, 6,  32'h60,       0, 0,  32'h0);
    vecs[18] = mk(0, 1, 1, 3,  32'h30,       32'h1 << 6,              1, 11, 32'hB0,       0, 0,  32'h0);
    vecs[19] = mk(1, 1, 1, 6,  32'h60,       32'h0,                   1, 11, 32'hB0,       0, 0,  32'h0);
    vecs[20] = mk(0, 1, 0, 6,  32'h60,       32'h1 << 11,             0, 0,  32'h0,        0, 0,  32'h0);
    vecs[21] = mk(1, 1, 1, 11, 32'hB0,       32'h0,                   0, 0,  32'h0,        0, 0,  32'h0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      check($sformatf("v%0d a_ready", k), 64'(a_ready), 64'(vecs[k].ear));
      check($sformatf("v%0d b_ready", k), 64'(b_ready), 64'(vecs[k].ebr));
      check($sformatf("v%0d wb_we", k), 64'(wb_we), 64'(vecs[k].ewe));
      check($sformatf("v%0d wb_addr", k), 64'(wb_addr), 64'(vecs[k].ewa));
      check($sformatf("v%0d wb_data", k), 64'(wb_data), 64'(vecs[k].ewd));
      check($sformatf("v%0d busy_vec", k), 64'(busy_vec), 64'(vecs[k].ebusy));
      a_valid = vecs[k].av; a_addr = vecs[k].aa; a_data = vecs[k].ad;
      b_valid = vecs[k].bv; b_addr = vecs[k].ba; b_data = vecs[k].bd;
    end

    // Accept-to-write latency and busy duration for one isolated request
    @(negedge clk);
    idle_inputs();
    a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    n  = 1;
    bc = busy_vec[20] ? 1 : 0;
    while (!wb_we && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (busy_vec[20]) bc++;
    end
    check("lat_edges", 64'(n), 64'd2);
    check("lat_addr", 64'(wb_addr), 64'd20);
    check("lat_data", 64'(wb_data), 64'hCAFEF00D);
    check("lat_busy_cycles", 64'(bc), 64'd1);

    // Asynchronous reset while a write is on the port and slot B still holds an entry
    @(negedge clk);
    idle_inputs();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD0;
    @(negedge clk);
    idle_inputs();
    check("rst_pre_a_ready", 64'(a_ready), 64'd0);
    check("rst_pre_b_ready", 64'(b_ready), 64'd0);
    @(negedge clk);
    check("rst_pre_we", 64'(wb_we), 64'd1);
    check("rst_pre_busy", 64'(busy_vec), 64'(32'h1 << 13));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_we", 64'(wb_we), 64'd0);
    check("rst_async_a_ready", 64'(a_ready), 64'd1);
    check("rst_async_b_ready", 64'(b_ready), 64'd1);
    check("rst_async_busy", 64'(busy_vec), 64'd0);
    check("rst_async_addr", 64'(wb_addr), 64'd0);
    check("rst_async_data", 64'(wb_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d we", k), 64'(wb_we), 64'd0);
      check($sformatf("post_rst%0d busy", k), 64'(busy_vec), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
